instr_decode: RTL
=================

# instr_decode

Instruction register and decoder sitting directly upstream of `global_fsm`. It captures the 16-bit instruction word from memory when the FSM asserts its IR enable, then decodes it into the fields the FSM consumes:
- opcode
- rdst/rsrc mux selects
- immediate
- instruction class (`flag_type`)
- one-hot register-bank write enable

Decoded fields are registered, so they are stable for every FSM state until the next IR load.

## Interface
Parameters:
- `WORD_W`, 16, instruction word width.
- `NREGS`, 16, register-bank size; width of the one-hot write vector.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ir_en`  in  1  load strobe from FSM `IR_enable`.
- `flush`  in  1  discard current instruction; force NOP decode.
- `instr_in`  in  16  instruction word from memory read port.
- `ir_out`  out  16  raw latched instruction.
- `opcode_out`  out  8  ALU control, to FSM `opcode_in`.
- `rdst_out`  out  5  destination select, to FSM `rdst_in`.
- `rsrc_out`  out  5  source select, to FSM `rsrc_in`.
- `immediate_out`  out  8  immediate field, to FSM `immediate_in`.
- `flag_type`  out  4  instruction class, to FSM `flag_type`.
- `rdst_write_out`  out  16  one-hot bank write enable, to FSM `rdst_write_in`.
- `valid`  out  1  a decoded instruction is held.
- `illegal`  out  1  held instruction is not a legal encoding.
- `illegal_seen`  out  1  sticky; set on any illegal load.
- `instr_count`  out  16  number of instructions loaded.

## Operation
Field split of `instr_in`:
- `op` = [15:12]
- `rd` = [11:8]
- `ext` = [7:4]
- `rs` = [3:0]
- `imm` = [7:0]

Classes and `flag_type`:
- R-type (`op`=0000; `ext` ∈ {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV}) → 0001.
  - `opcode_out` = {`op`, `ext`}.
  - `immediate_out` = 0.
- I-type (`op` ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101}) → 0010.
  - `opcode_out` = {`op`, 4'b0000}.
  - `immediate_out` = `imm`.
  - `rsrc_out` = 0.
- LOAD (`op`=0100, `ext`=0000) → 0100.
- STOR (`op`=0100, `ext`=0100) → 0101.
  - For both LOAD and STOR: `opcode_out` = {`op`, `ext`}, `immediate_out` = 0.
- Anything else is illegal:
  - `flag_type` = 0000 (FSM stays in fetch).
  - `opcode_out` = 0.
  - `rdst_write_out` = 0.
  - `illegal` = 1.

Register selects: `rdst_out` = {1'b0, `rd`}; `rsrc_out` = {1'b0, `rs`}, except for I-type as stated above.

`rdst_write_out` = 1 << `rd` for R-type, I-type and LOAD, except CMP and CMPI, which write flags only. It is 0 for CMP, CMPI, STOR and illegal encodings.

Decode is combinational from `instr_in`; the results are captured into output registers together with `ir_out`.

## Timing
Reset (`reset`=1 at a rising edge): every output becomes 0, including `ir_out`, `valid`, `illegal_seen` and `instr_count`. Reset overrides `ir_en` and `flush`.

- **Load:** with `ir_en`=1 and `flush`=0 at edge N:
  - `ir_out` and all decoded outputs reflect `instr_in` sampled at N, visible from N+1 on (one-cycle latency).
  - `valid` ← 1.
  - `instr_count` ← `instr_count`+1, wrapping at 0xFFFF→0x0000.
  - If the encoding is illegal, `illegal_seen` ← 1.
- **Hold:** with `ir_en`=0, all outputs keep their values indefinitely. `instr_in` changes are ignored.
- **Flush:**
  - `flush`=1 → `valid` ← 0, all decoded outputs ← 0, `ir_out` ← 0.
  - `instr_count` and `illegal_seen` are unchanged.
  - Flush wins over a simultaneous `ir_en` (the instruction is neither captured nor counted).
- **Back-to-back loads:** `ir_en` held high loads every cycle; each edge counts one instruction.
- **Illegal flag:** `illegal` is not sticky. It tracks the held instruction and clears on the next legal load or on flush.
- **Sticky flag:** `illegal_seen` clears only on reset.

## Test plan
- Reset, then load 0x0351 (ADD r3,r1) with `ir_en`=1 → next cycle `opcode_out`=0x05, `rdst_out`=3, `rsrc_out`=1, `flag_type`=0001, `rdst_write_out`=0x0008, `valid`=1, `instr_count`=1.
- Load 0x5A7F (ADDI r10,#0x7F), then drop `ir_en` and drive `instr_in`=0xFFFF for 3 cycles → `opcode_out`=0x50, `immediate_out`=0x7F, `rdst_write_out`=0x0400, `flag_type`=0010, all held unchanged.
- Load 0x4240 (STOR), then 0x4502 (LOAD r5,r2) → STOR: `flag_type`=0101, `rdst_write_out`=0. LOAD: `flag_type`=0100, `rdst_write_out`=0x0020, `rsrc_out`=2.
- Load 0x0BB2 (CMP) → `rdst_write_out`=0. Then load 0xF000 → `illegal`=1, `flag_type`=0000, `illegal_seen`=1. Then load 0x0351 → `illegal`=0, `illegal_seen` still 1.
- Assert `flush` and `ir_en` together with `instr_in`=0x0351 → `valid`=0, outputs 0, `instr_count` unchanged. Then assert `reset` mid-stream → all outputs 0 on the next cycle.
- Preset `instr_count` to 0xFFFF via 65535 loads, then load once more → `instr_count`=0x0000.

Source files
------------

// File: rtl/instr_decode.sv
// Instruction register and decoder feeding global_fsm.
// Captures the instruction word on ir_en and holds the registered decode fields until the next load.
module instr_decode #(
  parameter int WORD_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_en,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] ir_out,
  output logic [7:0]        opcode_out,
  output logic [4:0]        rdst_out,
  output logic [4:0]        rsrc_out,
  output logic [7:0]        immediate_out,
  output logic [3:0]        flag_type,
  output logic [NREGS-1:0]  rdst_write_out,
  output logic              valid,
  output logic              illegal,
  output logic              illegal_seen,
  output logic [15:0]       instr_count
);

  localparam logic [3:0] FT_NONE = 4'b0000;
  localparam logic [3:0] FT_R    = 4'b0001;
  localparam logic [3:0] FT_I    = 4'b0010;
  localparam logic [3:0] FT_LOAD = 4'b0100;
  localparam logic [3:0] FT_STOR = 4'b0101;

  logic [3:0]       op_s;
  logic [3:0]       rd_s;
  logic [3:0]       ext_s;
  logic [3:0]       rs_s;
  logic [7:0]       imm_s;

  logic [7:0]       opcode_s;
  logic [4:0]       rdst_s;
  logic [4:0]       rsrc_s;
  logic [7:0]       immediate_s;
  logic [3:0]       flag_type_s;
  logic [NREGS-1:0] rdst_write_s;
  logic             illegal_s;

  // The same seven ALU codes are legal as an R-type ext field and as an I-type op field.
  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b1001, 4'b1011, 4'b1101: is_alu_code = 1'b1;
      default:                   is_alu_code = 1'b0;
    endcase
  endfunction

  function automatic logic [NREGS-1:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign op_s  = instr_in[15:12];
  assign rd_s  = instr_in[11:8];
  assign ext_s = instr_in[7:4];
  assign rs_s  = instr_in[3:0];
  assign imm_s = instr_in[7:0];

  // Combinational decode of the incoming instruction word.
  always_comb begin
    opcode_s     = 8'h00;
    rdst_s       = {1'b0, rd_s};
    rsrc_s       = {1'b0, rs_s};
    immediate_s  = 8'h00;
    flag_type_s  = FT_NONE;
    rdst_write_s = {NREGS{1'b0}};
    illegal_s    = 1'b1;
    case (op_s)
      4'b0000: begin
        if (is_alu_code(ext_s)) begin
          opcode_s     = {op_s, ext_s};
          flag_type_s  = FT_R;
          illegal_s    = 1'b0;
          // CMP only updates flags
          rdst_write_s = (ext_s == 4'b1011) ? {NREGS{1'b0}} : reg_onehot(rd_s);
        end else begin
          illegal_s    = 1'b1;
        end
      end
      4'b0100: begin
        if (ext_s == 4'b0000) begin
          opcode_s     = {op_s, ext_s};
          flag_type_s  = FT_LOAD;
          rdst_write_s = reg_onehot(rd_s);
          illegal_s    = 1'b0;
        end else if (ext_s == 4'b0100) begin
          opcode_s     = {op_s, ext_s};
          flag_type_s  = FT_STOR;
          illegal_s    = 1'b0;
        end else begin
          illegal_s    = 1'b1;
        end
      end
      default: begin
        if (is_alu_code(op_s)) begin
          opcode_s     = {op_s, 4'b0000};
          immediate_s  = imm_s;
          rsrc_s       = 5'd0;
          flag_type_s  = FT_I;
          illegal_s    = 1'b0;
          rdst_write_s = (op_s == 4'b1011) ? {NREGS{1'b0}} : reg_onehot(rd_s);
        end else begin
          illegal_s    = 1'b1;
        end
      end
    endcase
  end

  // Instruction register plus registered decode outputs, counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_out         <= {WORD_W{1'b0}};
      opcode_out     <= 8'h00;
      rdst_out       <= 5'd0;
      rsrc_out       <= 5'd0;
      immediate_out  <= 8'h00;
      flag_type      <= 4'b0000;
      rdst_write_out <= {NREGS{1'b0}};
      valid          <= 1'b0;
      illegal        <= 1'b0;
      illegal_seen   <= 1'b0;
      instr_count    <= 16'h0000;
    end else if (flush) begin
      ir_out         <= {WORD_W{1'b0}};
      opcode_out     <= 8'h00;
      rdst_out       <= 5'd0;
      rsrc_out       <= 5'd0;
      immediate_out  <= 8'h00;
      flag_type      <= 4'b0000;
      rdst_write_out <= {NREGS{1'b0}};
      valid          <= 1'b0;
      illegal        <= 1'b0;
    end else if (ir_en) begin
      ir_out         <= instr_in;
      opcode_out     <= opcode_s;
      rdst_out       <= rdst_s;
      rsrc_out       <= rsrc_s;
      immediate_out  <= immediate_s;
      flag_type      <= flag_type_s;
      rdst_write_out <= rdst_write_s;
      valid          <= 1'b1;
      illegal        <= illegal_s;
      illegal_seen   <= illegal_seen | illegal_s;
      instr_count    <= instr_count + 16'h0001;
    end else begin
      ir_out         <= ir_out;
      instr_count    <= instr_count;
    end
  end

endmodule
